chess_input_ctrl: RTL and testbench
===================================

Name: chess_input_ctrl

Overview:
Front-end controller converting the six raw board buttons into the cursor/selection signals consumed by the LCD board renderer, plus a move-request handshake toward the game logic. Synchronises and debounces each button, moves a 6-bit cursor {row,col} over the 8x8 board, and runs a select-source / select-destination FSM. Sits directly upstream of the LCD renderer; shares clock domain clk12.

Parameters:
DEBOUNCE_CYCLES, 120000, consecutive stable cycles before a button level is accepted (10 ms at 12 MHz)
CNT_W, 17, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
CURSOR_INIT, 6'b001_100, cursor value after reset (row 1, col 4)
WRAP, 0, 0 = clamp at board edge, 1 = wrap modulo 8

Ports:
clk12  in  1  system clock, 12 MHz
reset  in  1  synchronous, active-high
btn_up  in  1  raw button, active-high, asynchronous, bouncy
btn_down  in  1  raw button, same
btn_left  in  1  raw button, same
btn_right  in  1  raw button, same
btn_enter  in  1  raw button, same
btn_esc  in  1  raw button, same
move_ready  in  1  game logic accepts move_from/move_to
cursor  out  6  [5:3] row (7 = top of display), [2:0] col (0 = left)
enter_pressed  out  1  level: a source square is selected
esc_pressed  out  1  one-cycle pulse on accepted esc press
move_valid  out  1  move request pending
move_from  out  6  source square {row,col}
move_to  out  6  destination square {row,col}

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk12.
- Reset: cursor=CURSOR_INIT, enter_pressed=0, esc_pressed=0, move_valid=0, move_from=0, move_to=0, FSM=IDLE, debounced levels=0, counters=0, synchroniser flops=0.
- Per button: 2-flop synchroniser; debounced level changes only after sync value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter. Press event = one-cycle pulse on debounced 0->1. Release generates nothing. Raw-to-event latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
- Cursor (IDLE/SELECTED only): up row+1, down row-1, right col+1, left col-1; updates the cycle after the event. Edge: WRAP=0 holds at 0/7; WRAP=1 wraps 7->0, 0->7 (3-bit modulo). Same-cycle up+down cancel on row; left+right cancel on col; row and col events in the same cycle both apply.
- FSM:
  IDLE: enter -> move_from<=cursor, enter_pressed<=1, SELECTED. esc -> pulse only, stay.
  SELECTED: esc -> enter_pressed<=0, IDLE. enter with cursor==move_from -> deselect, enter_pressed<=0, IDLE. enter with cursor!=move_from -> move_to<=cursor, move_valid<=1, ISSUE. enter and esc same cycle: esc wins.
  ISSUE: move_valid, move_from, move_to, cursor held stable; direction/enter/esc events discarded (esc_pressed still pulses). Cycle with move_valid&&move_ready -> move_valid<=0, enter_pressed<=0, IDLE next cycle. enter_pressed stays 1 throughout ISSUE.
- Direction event in the same cycle as enter: enter samples pre-move cursor; cursor then moves.
- esc_pressed pulses exactly 1 cycle per accepted esc event in every state.
- Reset mid-operation (any state, mid-debounce) returns all state to reset values next edge; pending move discarded.
- move_ready while move_valid=0 ignored.

Decomposition:
- chess_pkg: fsm state enum (IDLE, SELECTED, ISSUE), square type {row[2:0],col[2:0]}, BTN_UP..BTN_ESC index constants, ROW_MAX=7/COL_MAX=7.
- Sub-module button_debounce (sync + counter + rising-edge pulse, params DEBOUNCE_CYCLES/CNT_W), instantiated 6 times; top holds cursor datapath and FSM.

Test Plan (bench DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset, press btn_right 3 clean times -> cursor 001_100 -> 001_111; 4th press with WRAP=0 stays 001_111; WRAP=1 gives 001_000.
- btn_up bounces 1-0-1 within 3 cycles then holds 1 -> exactly one event, row increments once, at 2+4+1 cycles after last edge.
- enter at 001_100, up x2, enter -> move_valid=1, move_from=001_100, move_to=011_100; move_ready low 5 cycles then high -> move_valid holds 5 cycles, drops after accept, enter_pressed=0, IDLE.
- enter at 000_000, esc -> esc_pressed one-cycle pulse, enter_pressed=0, move_valid never asserted; enter twice on same square -> deselect, no move.
- In ISSUE, press left and esc -> cursor unchanged, esc_pressed pulses, move_valid stays 1 with same from/to.
- Assert reset while SELECTED with a debounce counter at 3 -> next cycle cursor=001_100, enter_pressed=0, no spurious press event afterwards.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared types and constants for the chess board input front-end.
// Cursor and squares are {row,col}; row 7 is the top of the display.
package chess_pkg;

   typedef enum logic [1:0] {IDLE, SELECTED, ISSUE} fsm_t;

   typedef struct packed {
      logic [2:0] row;
      logic [2:0] col;
   } square_t;

   localparam int NUM_BTN   = 6;
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_ENTER = 4;
   localparam int BTN_ESC   = 5;
   localparam int ROW_MAX   = 7;
   localparam int COL_MAX   = 7;

   // One axis step; opposing events in the same cycle cancel.
   function automatic logic [2:0] step3(input logic [2:0] v, input logic inc,
                                        input logic dec, input logic wrap,
                                        input logic [2:0] max);
      logic [2:0] r;
      r = v;
      if (inc && !dec)
         r = (v == max) ? (wrap ? 3'd0 : v) : v + 3'd1;
      else if (dec && !inc)
         r = (v == 3'd0) ? (wrap ? max : v) : v - 3'd1;
      return r;
   endfunction

endpackage

// File: rtl/chess_input_ctrl_debounce.sv
// Per-button 2-flop synchroniser, stability counter and press pulse.
// Pulse appears 2 + DEBOUNCE_CYCLES + 1 cycles after a clean raw edge.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int CNT_W           = 17
) (
   input  logic clk12,
   input  logic reset,
   input  logic raw,
   output logic press
);

   logic             sync1, sync2, level, level_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk12) begin
      if (reset) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_q <= level;
         press   <= level & ~level_q;
         // Any cycle agreeing with the accepted level restarts the count.
         if (sync2 == level)
            cnt <= '0;
         else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
         end else
            cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/chess_input_ctrl.sv
// Button front-end: debounced events drive the board cursor and the
// select-source / select-destination FSM that issues move requests.
module chess_input_ctrl
   import chess_pkg::*;
#(
   parameter int         DEBOUNCE_CYCLES = 120000,
   parameter int         CNT_W           = 17,
   parameter logic [5:0] CURSOR_INIT     = 6'b001_100,
   parameter bit         WRAP            = 1'b0
) (
   input  logic       clk12,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_enter,
   input  logic       btn_esc,
   input  logic       move_ready,
   output logic [5:0] cursor,
   output logic       enter_pressed,
   output logic       esc_pressed,
   output logic       move_valid,
   output logic [5:0] move_from,
   output logic [5:0] move_to
);

   logic [NUM_BTN-1:0] btn_raw, ev;
   fsm_t               state, state_n;
   square_t            cur, cur_n, from_q, from_n, to_q, to_n;
   logic               sel_q, sel_n, mv_q, mv_n;

   assign btn_raw = {btn_esc, btn_enter, btn_right, btn_left, btn_down, btn_up};

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db [NUM_BTN-1:0] (
      .clk12 (clk12),
      .reset (reset),
      .raw   (btn_raw),
      .press (ev)
   );

   always_ff @(posedge clk12) begin
      if (reset) begin
         state  <= IDLE;
         cur    <= square_t'(CURSOR_INIT);
         from_q <= '0;
         to_q   <= '0;
         sel_q  <= 1'b0;
         mv_q   <= 1'b0;
      end else begin
         state  <= state_n;
         cur    <= cur_n;
         from_q <= from_n;
         to_q   <= to_n;
         sel_q  <= sel_n;
         mv_q   <= mv_n;
      end
   end

   always_comb begin
      state_n = state;
      cur_n   = cur;
      from_n  = from_q;
      to_n    = to_q;
      sel_n   = sel_q;
      mv_n    = mv_q;
      // The cursor is frozen while a move request is outstanding.
      if (state != ISSUE) begin
         cur_n.row = step3(cur.row, ev[BTN_UP], ev[BTN_DOWN], WRAP, 3'(ROW_MAX));
         cur_n.col = step3(cur.col, ev[BTN_RIGHT], ev[BTN_LEFT], WRAP, 3'(COL_MAX));
      end
      case (state)
         IDLE: if (ev[BTN_ENTER]) begin
            from_n  = cur;
            sel_n   = 1'b1;
            state_n = SELECTED;
         end
         SELECTED: if (ev[BTN_ESC]) begin
            sel_n   = 1'b0;
            state_n = IDLE;
         end else if (ev[BTN_ENTER]) begin
            if (cur == from_q) begin
               sel_n   = 1'b0;
               state_n = IDLE;
            end else begin
               to_n    = cur;
               mv_n    = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: if (mv_q && move_ready) begin
            mv_n    = 1'b0;
            sel_n   = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign cursor        = cur;
   assign enter_pressed = sel_q;
   assign esc_pressed   = ev[BTN_ESC];
   assign move_valid    = mv_q;
   assign move_from     = from_q;
   assign move_to       = to_q;

endmodule

// File: tb/tb_chess_input_ctrl.sv
// Scoreboard bench: stimulus queues expected output snapshots, a monitor
// pops one on every observed change of the output bundle.
module tb_chess_input_ctrl;

   logic       clk12 = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] btn   = '0;   // {esc,enter,right,left,down,up}
   logic       move_ready = 1'b0;
   logic [5:0] cursor, move_from, move_to, cursor_w, from_w, to_w;
   logic       enter_pressed, esc_pressed, move_valid, ep_w, esc_w, mv_w;

   typedef struct {
      logic [20:0] s;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   int          nchk = 0, nerr = 0, cyc = 0;
   bit          mon_en = 1'b0;
   logic [20:0] now_s, prev_s;
   exp_t        e;

   localparam logic [5:0] UP = 6'b000001, DN = 6'b000010, LF = 6'b000100,
                          RT = 6'b001000, EN = 6'b010000, ES = 6'b100000;

   chess_input_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .CURSOR_INIT(6'b001_100), .WRAP(1'b0)) dut (
      .clk12(clk12), .reset(reset), .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]),
      .btn_right(btn[3]), .btn_enter(btn[4]), .btn_esc(btn[5]), .move_ready(move_ready),
      .cursor(cursor), .enter_pressed(enter_pressed), .esc_pressed(esc_pressed),
      .move_valid(move_valid), .move_from(move_from), .move_to(move_to));

   chess_input_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .CURSOR_INIT(6'b001_100), .WRAP(1'b1)) dut_w (
      .clk12(clk12), .reset(reset), .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]),
      .btn_right(btn[3]), .btn_enter(btn[4]), .btn_esc(btn[5]), .move_ready(move_ready),
      .cursor(cursor_w), .enter_pressed(ep_w), .esc_pressed(esc_w),
      .move_valid(mv_w), .move_from(from_w), .move_to(to_w));

   always #5 clk12 = ~clk12;
   always @(posedge clk12) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic ex(input logic [5:0] c, input logic ep, input logic esc, input logic mv,
                     input logic [5:0] f, input logic [5:0] t, input int at = -1);
      exp_t x;
      x.s   = {c, ep, esc, mv, f, t};
      x.cyc = at;
      q.push_back(x);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk12);
      #1;
   endtask

   task automatic press(input logic [5:0] m);
      btn = btn | m;
      tick(10);
      btn = btn & ~m;
      tick(10);
   endtask

   // Monitor: every change of {cursor,enter,esc,valid,from,to} consumes one expectation.
   initial begin
      prev_s = 'x;
      forever begin
         @(negedge clk12);
         if (mon_en) begin
            now_s = {cursor, enter_pressed, esc_pressed, move_valid, move_from, move_to};
            if (now_s !== prev_s) begin
               if (q.size() == 0)
                  check("unexpected_change", {11'd0, now_s}, {11'd0, prev_s});
               else begin
                  e = q.pop_front();
                  check("snapshot", {11'd0, now_s}, {11'd0, e.s});
                  if (e.cyc >= 0) check("latency", cyc, e.cyc);
               end
            end
            prev_s = now_s;
         end
      end
   end

   initial begin
      int n;
      // Reset state
      tick(3);
      ex(6'b001100, 0, 0, 0, 6'o00, 6'o00);
      mon_en = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(2);

      // Right x3 then clamp; wrap instance rolls to col 0
      ex(6'b001101, 0, 0, 0, 0, 0); press(RT);
      ex(6'b001110, 0, 0, 0, 0, 0); press(RT);
      ex(6'b001111, 0, 0, 0, 0, 0); press(RT);
      press(RT);
      check("wrap_cursor", {26'd0, cursor_w}, 32'b001000);
      ex(6'b001110, 0, 0, 0, 0, 0); press(LF);
      ex(6'b001101, 0, 0, 0, 0, 0); press(LF);
      ex(6'b001100, 0, 0, 0, 0, 0); press(LF);

      // Bouncy up: one event, cursor updates one cycle after the event
      btn[0] = 1'b1; tick(1);
      btn[0] = 1'b0; tick(1);
      btn[0] = 1'b1; n = cyc;
      ex(6'b010100, 0, 0, 0, 0, 0, n + 8);
      tick(12);
      btn[0] = 1'b0; tick(10);
      ex(6'b001100, 0, 0, 0, 0, 0); press(DN);

      // Select, move up twice, issue, delayed accept
      ex(6'b001100, 1, 0, 0, 6'b001100, 0); press(EN);
      ex(6'b010100, 1, 0, 0, 6'b001100, 0); press(UP);
      ex(6'b011100, 1, 0, 0, 6'b001100, 0); press(UP);
      ex(6'b011100, 1, 0, 1, 6'b001100, 6'b011100); press(EN);
      tick(5);
      move_ready = 1'b1; n = cyc;
      ex(6'b011100, 0, 0, 0, 6'b001100, 6'b011100, n + 1);
      tick(1);
      move_ready = 1'b0;
      tick(3);

      // Walk to 000_000
      ex(6'b010100, 0, 0, 0, 6'b001100, 6'b011100); press(DN);
      ex(6'b001100, 0, 0, 0, 6'b001100, 6'b011100); press(DN);
      ex(6'b000100, 0, 0, 0, 6'b001100, 6'b011100); press(DN);
      ex(6'b000011, 0, 0, 0, 6'b001100, 6'b011100); press(LF);
      ex(6'b000010, 0, 0, 0, 6'b001100, 6'b011100); press(LF);
      ex(6'b000001, 0, 0, 0, 6'b001100, 6'b011100); press(LF);
      ex(6'b000000, 0, 0, 0, 6'b001100, 6'b011100); press(LF);
      press(LF);

      // Select then esc; select twice on same square deselects
      ex(6'b000000, 1, 0, 0, 6'b000000, 6'b011100); press(EN);
      ex(6'b000000, 1, 1, 0, 6'b000000, 6'b011100);
      ex(6'b000000, 0, 0, 0, 6'b000000, 6'b011100); press(ES);
      ex(6'b000000, 1, 0, 0, 6'b000000, 6'b011100); press(EN);
      ex(6'b000000, 0, 0, 0, 6'b000000, 6'b011100); press(EN);
      move_ready = 1'b1; tick(3); move_ready = 1'b0;

      // In ISSUE, left+esc: only the esc pulse is visible
      ex(6'b000000, 1, 0, 0, 6'b000000, 6'b011100); press(EN);
      ex(6'b000001, 1, 0, 0, 6'b000000, 6'b011100); press(RT);
      ex(6'b000001, 1, 0, 1, 6'b000000, 6'b000001); press(EN);
      ex(6'b000001, 1, 1, 1, 6'b000000, 6'b000001);
      ex(6'b000001, 1, 0, 1, 6'b000000, 6'b000001); press(LF | ES);
      ex(6'b000001, 0, 0, 0, 6'b000000, 6'b000001);
      move_ready = 1'b1; tick(1); move_ready = 1'b0; tick(3);

      // Reset while SELECTED with the up debounce counter at 3
      ex(6'b000001, 1, 0, 0, 6'b000001, 6'b000001); press(EN);
      btn[0] = 1'b1;
      tick(5);
      ex(6'b001100, 0, 0, 0, 6'b000000, 6'b000000);
      reset = 1'b1; btn[0] = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(20);

      check("scoreboard_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
